// File: rtl/rob_commit.sv
// rob_commit -- reorder buffer with in-order retirement.
//
// Purpose:
//   Circular queue of 2**ROB_WIDTH_BIT in-flight instructions. The decoder
//   allocates entries at the tail, the CDB marks them complete, and the head
//   retires one complete entry per cycle onto the register-file commit port.
//   A mispredicted branch reaching the head flushes the whole buffer and
//   requests a fetch redirect. Two combinational forwarding query ports let
//   the decoder read renamed operands, with same-cycle CDB bypass.
//
// Ports:
//   clk_in, rst_in (sync, active high), rdy_in (low = freeze)
//   issue_*        : allocation request from the decoder
//   rob_full       : every entry occupied (from registered count)
//   tail_id        : id the next accepted issue receives
//   cdb_*          : completion broadcast
//   q1_*, q2_*     : operand forwarding queries
//   write_en, reg_id, rob_id, value : registered regfile commit port
//   store_commit   : head STORE retired (id on rob_id)
//   clear_all, redirect_en, redirect_pc : flush and fetch redirect
//   halt           : sticky, set when an EXIT entry retires
//
// Optional build macro:
//   ROB_COMMIT_COUNTER_EN -- adds output commit_count[31:0], the number of
//   entries retired since reset.

module rob_commit #(
   parameter int ROB_WIDTH_BIT = 3,
   parameter int REG_ID_BIT    = 5
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     rdy_in,
   input  logic                     issue_valid,
   input  logic [1:0]               issue_type,
   input  logic [REG_ID_BIT-1:0]    issue_rd,
   input  logic                     issue_ready,
   input  logic [31:0]              issue_value,
   input  logic [31:0]              issue_pred_pc,
   output logic                     rob_full,
   output logic [ROB_WIDTH_BIT-1:0] tail_id,
   input  logic                     cdb_valid,
   input  logic [ROB_WIDTH_BIT-1:0] cdb_rob_id,
   input  logic [31:0]              cdb_value,
   input  logic [31:0]              cdb_next_pc,
   input  logic [ROB_WIDTH_BIT-1:0] q1_id,
   input  logic [ROB_WIDTH_BIT-1:0] q2_id,
   output logic                     q1_ready,
   output logic                     q2_ready,
   output logic [31:0]              q1_value,
   output logic [31:0]              q2_value,
   output logic                     write_en,
   output logic [REG_ID_BIT-1:0]    reg_id,
   output logic [ROB_WIDTH_BIT-1:0] rob_id,
   output logic [31:0]              value,
   output logic                     store_commit,
   output logic                     clear_all,
   output logic                     redirect_en,
   output logic [31:0]              redirect_pc,
`ifdef ROB_COMMIT_COUNTER_EN
   output logic [31:0]              commit_count,
`endif
   output logic                     halt
);

   localparam int DEPTH = 1 << ROB_WIDTH_BIT;
   localparam int CW    = ROB_WIDTH_BIT + 1;

   localparam logic [1:0] T_REG    = 2'd0;
   localparam logic [1:0] T_STORE  = 2'd1;
   localparam logic [1:0] T_BRANCH = 2'd2;
   localparam logic [1:0] T_EXIT   = 2'd3;

   // Control state (reset) and payload storage (no reset: payload is only
   // ever read while the matching valid bit is set).
   logic [ROB_WIDTH_BIT-1:0] head_reg;
   logic [ROB_WIDTH_BIT-1:0] tail_reg;
   logic [CW-1:0]            count_reg;
   logic [DEPTH-1:0]         valid_reg;
   logic [DEPTH-1:0]         ready_reg;

   logic [1:0]               type_reg  [DEPTH];
   logic [REG_ID_BIT-1:0]    rd_reg    [DEPTH];
   logic [31:0]              value_reg [DEPTH];
   logic [31:0]              pred_reg  [DEPTH];
   logic [31:0]              npc_reg   [DEPTH];

   logic issue_accept;
   logic cdb_accept;
   logic head_commit;
   logic head_mispredict;
   logic head_writes_reg;

   assign rob_full = (count_reg == CW'(DEPTH));
   // tail is already zero while clear_all is high (the flush zeroed it).
   assign tail_id  = tail_reg;

   // halt freezes allocation and retirement; clear_all marks the cycle in
   // which the rest of the machine is being flushed, so inputs are stale.
   assign issue_accept = issue_valid && !rob_full && !clear_all && !halt;
   assign cdb_accept   = cdb_valid && !clear_all && valid_reg[cdb_rob_id];

   // Retirement looks at stored ready only; a CDB result arriving this cycle
   // retires one cycle later.
   assign head_commit     = !halt && valid_reg[head_reg] && ready_reg[head_reg];
   assign head_mispredict = head_commit && (type_reg[head_reg] == T_BRANCH) &&
                            (npc_reg[head_reg] != pred_reg[head_reg]);
   assign head_writes_reg = ((type_reg[head_reg] == T_REG) ||
                             (type_reg[head_reg] == T_BRANCH)) &&
                            (rd_reg[head_reg] != '0);

   // Forwarding query ports: a matching CDB broadcast takes priority over
   // the stored entry.
   logic [ROB_WIDTH_BIT-1:0] q_id  [2];
   logic                     q_rdy [2];
   logic [31:0]              q_val [2];

   assign q_id[0]  = q1_id;
   assign q_id[1]  = q2_id;
   assign q1_ready = q_rdy[0];
   assign q2_ready = q_rdy[1];
   assign q1_value = q_val[0];
   assign q2_value = q_val[1];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_query
         always_comb begin
            q_rdy[gi] = 1'b0;
            q_val[gi] = '0;
            if (cdb_valid && (cdb_rob_id == q_id[gi])) begin
               q_rdy[gi] = 1'b1;
               q_val[gi] = cdb_value;
            end else if (valid_reg[q_id[gi]] && ready_reg[q_id[gi]]) begin
               q_rdy[gi] = 1'b1;
               q_val[gi] = value_reg[q_id[gi]];
            end
         end
      end
   endgenerate

   // Payload writes. The issue write comes last so it wins over a CDB write
   // aimed at the same (necessarily invalid) slot.
   always_ff @(posedge clk_in) begin
      if (rdy_in) begin
         if (cdb_accept) begin
            value_reg[cdb_rob_id] <= cdb_value;
            npc_reg[cdb_rob_id]   <= cdb_next_pc;
         end
         if (issue_accept) begin
            type_reg[tail_reg]  <= issue_type;
            rd_reg[tail_reg]    <= issue_rd;
            value_reg[tail_reg] <= issue_value;
            pred_reg[tail_reg]  <= issue_pred_pc;
            // An entry complete at issue never mispredicts.
            npc_reg[tail_reg]   <= issue_pred_pc;
         end
      end
   end

   // Control state and registered commit outputs.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         head_reg     <= '0;
         tail_reg     <= '0;
         count_reg    <= '0;
         valid_reg    <= '0;
         ready_reg    <= '0;
         write_en     <= 1'b0;
         reg_id       <= '0;
         rob_id       <= '0;
         value        <= '0;
         store_commit <= 1'b0;
         clear_all    <= 1'b0;
         redirect_en  <= 1'b0;
         redirect_pc  <= '0;
         halt         <= 1'b0;
`ifdef ROB_COMMIT_COUNTER_EN
         commit_count <= '0;
`endif
      end else if (rdy_in) begin
         write_en     <= 1'b0;
         store_commit <= 1'b0;
         clear_all    <= 1'b0;
         redirect_en  <= 1'b0;

         if (head_commit) begin
            rob_id <= head_reg;
            if (head_writes_reg) begin
               write_en <= 1'b1;
               reg_id   <= rd_reg[head_reg];
               value    <= value_reg[head_reg];
            end
            if (type_reg[head_reg] == T_STORE) begin
               store_commit <= 1'b1;
            end
            if (type_reg[head_reg] == T_EXIT) begin
               halt <= 1'b1;
            end
`ifdef ROB_COMMIT_COUNTER_EN
            commit_count <= commit_count + 32'd1;
`endif
         end

         if (head_mispredict) begin
            // The branch's own link write above still goes out alongside
            // the flush; everything younger is discarded.
            clear_all   <= 1'b1;
            redirect_en <= 1'b1;
            redirect_pc <= npc_reg[head_reg];
            valid_reg   <= '0;
            ready_reg   <= '0;
            head_reg    <= '0;
            tail_reg    <= '0;
            count_reg   <= '0;
         end else begin
            if (cdb_accept) begin
               ready_reg[cdb_rob_id] <= 1'b1;
            end
            if (head_commit) begin
               valid_reg[head_reg] <= 1'b0;
               head_reg            <= head_reg + ROB_WIDTH_BIT'(1);
            end
            // tail==head with a committing head only when full, and a full
            // buffer never accepts, so these two slot writes never collide.
            if (issue_accept) begin
               valid_reg[tail_reg] <= 1'b1;
               ready_reg[tail_reg] <= issue_ready;
               tail_reg            <= tail_reg + ROB_WIDTH_BIT'(1);
            end
            count_reg <= count_reg + CW'(issue_accept) - CW'(head_commit);
         end
      end
   end

endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit -- self-checking bench for rob_commit.
// Directed scenarios followed by a randomized run, checked against an
// in-order queue model of the buffer kept in this file.

module tb_rob_commit;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        issue_valid;
   logic [1:0]  issue_type;
   logic [4:0]  issue_rd;
   logic        issue_ready;
   logic [31:0] issue_value;
   logic [31:0] issue_pred_pc;
   logic        rob_full;
   logic [2:0]  tail_id;
   logic        cdb_valid;
   logic [2:0]  cdb_rob_id;
   logic [31:0] cdb_value;
   logic [31:0] cdb_next_pc;
   logic [2:0]  q1_id, q2_id;
   logic        q1_ready, q2_ready;
   logic [31:0] q1_value, q2_value;
   logic        write_en;
   logic [4:0]  reg_id;
   logic [2:0]  rob_id;
   logic [31:0] value;
   logic        store_commit;
   logic        clear_all;
   logic        redirect_en;
   logic [31:0] redirect_pc;
   logic        halt;
`ifdef ROB_COMMIT_COUNTER_EN
   logic [31:0] commit_count;
`endif

   rob_commit #(.ROB_WIDTH_BIT(3), .REG_ID_BIT(5)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
      .issue_ready(issue_ready), .issue_value(issue_value),
      .issue_pred_pc(issue_pred_pc), .rob_full(rob_full), .tail_id(tail_id),
      .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
      .cdb_next_pc(cdb_next_pc), .q1_id(q1_id), .q2_id(q2_id),
      .q1_ready(q1_ready), .q2_ready(q2_ready), .q1_value(q1_value),
      .q2_value(q2_value), .write_en(write_en), .reg_id(reg_id),
      .rob_id(rob_id), .value(value), .store_commit(store_commit),
      .clear_all(clear_all), .redirect_en(redirect_en),
      .redirect_pc(redirect_pc),
`ifdef ROB_COMMIT_COUNTER_EN
      .commit_count(commit_count),
`endif
      .halt(halt)
   );

   always #5 clk_in = ~clk_in;

   int checks = 0;
   int failures = 0;

   // Model: program-ordered list of in-flight instructions.
   typedef struct {
      int          id;
      int          kind;   // 0 REG, 1 STORE, 2 BRANCH, 3 EXIT
      int          rd;
      bit          done;
      logic [31:0] val;
      logic [31:0] pred;
      logic [31:0] npc;
   } ent_t;

   ent_t mq[$];
   int   m_next_id = 0;
   int   m_retired = 0;
   bit   e_we, e_st, e_clr, e_redir, e_halt, e_after_rst;
   logic [31:0] e_regid, e_robid, e_val, e_rpc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_in();
      rdy_in = 1'b1; issue_valid = 1'b0; issue_type = 2'd0; issue_rd = 5'd0;
      issue_ready = 1'b0; issue_value = '0; issue_pred_pc = '0;
      cdb_valid = 1'b0; cdb_rob_id = '0; cdb_value = '0; cdb_next_pc = '0;
      q1_id = '0; q2_id = '0;
   endtask

   task automatic iss(input int t, input int rd, input bit r, input logic [31:0] v,
                      input logic [31:0] p);
      issue_valid = 1'b1; issue_type = 2'(t); issue_rd = 5'(rd);
      issue_ready = r; issue_value = v; issue_pred_pc = p;
   endtask

   task automatic cdb(input int id, input logic [31:0] v, input logic [31:0] npc);
      cdb_valid = 1'b1; cdb_rob_id = 3'(id); cdb_value = v; cdb_next_pc = npc;
   endtask

   task automatic fwd_exp(input int id, output bit r, output logic [31:0] v);
      r = 1'b0; v = '0;
      if (cdb_valid && int'(cdb_rob_id) == id) begin
         r = 1'b1; v = cdb_value;
      end else begin
         foreach (mq[i]) if (mq[i].id == id && mq[i].done) begin
            r = 1'b1; v = mq[i].val;
         end
      end
   endtask

   // One clock: check combinational outputs, advance the model, then check
   // the registered outputs after the edge. Called at the falling edge.
   task automatic cycle();
      bit          commit, mis, accept, flushing, halted, fr;
      logic [31:0] fv;
      ent_t        h, n;
      #1;
      if (!rst_in) begin
         chk("rob_full", rob_full, mq.size() == 8);
         chk("tail_id", tail_id, m_next_id);
         fwd_exp(q1_id, fr, fv);
         chk("q1_ready", q1_ready, fr);
         chk("q1_value", q1_value, fv);
         fwd_exp(q2_id, fr, fv);
         chk("q2_ready", q2_ready, fr);
         chk("q2_value", q2_value, fv);
      end
      e_after_rst = 1'b0;
      if (rst_in) begin
         mq.delete(); m_next_id = 0; m_retired = 0;
         e_we = 0; e_st = 0; e_clr = 0; e_redir = 0; e_halt = 0; e_after_rst = 1'b1;
      end else if (rdy_in) begin
         flushing = e_clr; halted = e_halt;
         commit = !halted && mq.size() > 0 && mq[0].done;
         mis = 1'b0;
         e_we = 0; e_st = 0; e_clr = 0; e_redir = 0;
         if (commit) begin
            h = mq[0];
            e_robid = h.id;
            m_retired++;
            if ((h.kind == 0 || h.kind == 2) && h.rd != 0) begin
               e_we = 1; e_regid = h.rd; e_val = h.val;
            end
            if (h.kind == 1) e_st = 1;
            if (h.kind == 3) e_halt = 1;
            mis = (h.kind == 2) && (h.npc != h.pred);
         end
         accept = issue_valid && mq.size() < 8 && !flushing && !halted;
         if (mis) begin
            e_clr = 1; e_redir = 1; e_rpc = h.npc;
            mq.delete(); m_next_id = 0;
         end else begin
            if (cdb_valid && !flushing)
               foreach (mq[i]) if (mq[i].id == int'(cdb_rob_id)) begin
                  mq[i].done = 1; mq[i].val = cdb_value; mq[i].npc = cdb_next_pc;
               end
            if (commit) void'(mq.pop_front());
            if (accept) begin
               n.id = m_next_id; n.kind = int'(issue_type); n.rd = int'(issue_rd);
               n.done = issue_ready; n.val = issue_value;
               n.pred = issue_pred_pc; n.npc = issue_pred_pc;
               mq.push_back(n);
               m_next_id = (m_next_id + 1) % 8;
            end
         end
      end
      @(posedge clk_in);
      #1;
      chk("write_en", write_en, e_we);
      chk("store_commit", store_commit, e_st);
      chk("clear_all", clear_all, e_clr);
      chk("redirect_en", redirect_en, e_redir);
      chk("halt", halt, e_halt);
      if (e_we) begin
         chk("reg_id", reg_id, e_regid);
         chk("value", value, e_val);
      end
      if (e_we || e_st) chk("rob_id", rob_id, e_robid);
      if (e_redir) chk("redirect_pc", redirect_pc, e_rpc);
      if (e_after_rst) begin
         chk("rst_reg_id", reg_id, 0);
         chk("rst_rob_id", rob_id, 0);
         chk("rst_value", value, 0);
         chk("rst_redirect_pc", redirect_pc, 0);
      end
`ifdef ROB_COMMIT_COUNTER_EN
      chk("commit_count", commit_count, m_retired);
`endif
      @(negedge clk_in);
   endtask

   task automatic do_reset();
      idle_in(); rst_in = 1'b1; cycle(); rst_in = 1'b0;
   endtask

   initial begin
      rst_in = 1'b1;
      idle_in();
      @(negedge clk_in);
      cycle(); cycle();
      rst_in = 1'b0;

      // Single REG completes via CDB and commits.
      idle_in(); iss(0, 5, 0, 0, 0); cycle();
      idle_in(); cdb(0, 32'h1234, 0); cycle();
      idle_in(); cycle(); cycle();
      chk("s1_value", value, 32'h1234);

      // Fill to capacity, drop the ninth issue, then wrap.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         idle_in(); iss(0, i + 1, 0, 32'(i), 0); cycle();
      end
      idle_in(); iss(0, 9, 0, 99, 0); cycle();
      idle_in(); cdb(0, 32'h55, 0); cycle();
      idle_in(); cycle();
      idle_in(); iss(0, 10, 0, 7, 0); cycle();
      idle_in(); cycle();

      // Out-of-order completion, in-order retirement.
      do_reset();
      idle_in(); iss(0, 3, 0, 0, 0); cycle();
      idle_in(); iss(0, 4, 0, 0, 0); cycle();
      idle_in(); cdb(1, 32'hB, 0); cycle();
      idle_in(); cdb(0, 32'hA, 0); cycle();
      for (int i = 0; i < 3; i++) begin idle_in(); cycle(); end

      // Mispredicted branch with younger entries present.
      do_reset();
      idle_in(); iss(2, 1, 0, 0, 32'h100); cycle();
      idle_in(); iss(0, 2, 0, 0, 0); cycle();
      idle_in(); iss(0, 3, 0, 0, 0); cycle();
      idle_in(); cdb(0, 32'h44, 32'h200); cycle();
      idle_in(); cycle();
      idle_in(); cdb(1, 32'h77, 0); iss(0, 6, 1, 5, 0); cycle();
      idle_in(); q1_id = 3'd1; cycle();
      idle_in(); cdb(1, 32'h88, 0); cycle();
      idle_in(); q1_id = 3'd1; cycle();

      // Same-cycle CDB bypass on a forwarding query.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         idle_in(); iss(0, i + 8, 0, 0, 0); cycle();
      end
      idle_in(); q1_id = 3'd3; q2_id = 3'd2; cdb(3, 32'hDEAD, 0); cycle();
      idle_in(); q1_id = 3'd3; cycle();

      // STORE then EXIT, then issues ignored under halt.
      do_reset();
      idle_in(); iss(1, 0, 1, 0, 0); cycle();
      idle_in(); iss(3, 0, 1, 0, 0); cycle();
      idle_in(); cycle(); cycle();
      idle_in(); iss(0, 4, 1, 9, 0); cycle();
      idle_in(); iss(0, 4, 1, 9, 0); cycle();
      idle_in(); cycle();

      // Randomized traffic including pauses and occasional resets.
      do_reset();
      for (int c = 0; c < 600; c++) begin
         idle_in();
         rdy_in = ($urandom_range(7) != 0);
         if ($urandom_range(99) == 0) rst_in = 1'b1;
         if ($urandom_range(1) == 1) begin
            int t;
            t = $urandom_range(2);
            iss(t, ($urandom_range(3) == 0) ? 0 : $urandom_range(31),
                (t != 2) && ($urandom_range(3) == 0), $urandom,
                ($urandom_range(1) == 1) ? 32'h100 : 32'h300);
         end
         if ($urandom_range(2) != 0) begin
            if (mq.size() > 0 && $urandom_range(3) != 0) begin
               int k;
               k = $urandom_range(mq.size() - 1);
               cdb(mq[k].id, $urandom,
                   ($urandom_range(3) == 0) ? mq[k].pred + 32'd4 : mq[k].pred);
            end else begin
               cdb($urandom_range(7), $urandom, $urandom);
            end
         end
         q1_id = 3'($urandom_range(7));
         q2_id = 3'($urandom_range(7));
         cycle();
         rst_in = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- Reorder buffer: circular queue of in-flight instructions, allocated by the decoder and completed by the CDB.
- Retires entries in program order at one per cycle. Each retirement drives the register file's commit port: write_en/reg_id/rob_id/value.
- On a mispredicted branch at the head, raises clear_all and a PC redirect.
- Also answers the decoder's operand-forwarding queries for renamed registers.

Parameters:
- ROB_WIDTH_BIT, 3, log2 of entry count (8 entries); entry ids are ROB_WIDTH_BIT wide.
- REG_ID_BIT, 5, architectural register index width.

Ports:
- clk_in  in  1  clock, all state updates on rising edge.
- rst_in  in  1  synchronous reset, active high.
- rdy_in  in  1  pause when low: no state change, registered outputs hold.
- issue_valid  in  1  decoder allocates an entry this cycle.
- issue_type  in  2  0=REG, 1=STORE, 2=BRANCH (branches and jumps), 3=EXIT.
- issue_rd  in  REG_ID_BIT  destination register (0 = none).
- issue_ready  in  1  result already known at issue (e.g. LUI).
- issue_value  in  32  result used when issue_ready=1.
- issue_pred_pc  in  32  predicted next PC (BRANCH only).
- rob_full  out  1  high when all entries are occupied.
- tail_id  out  ROB_WIDTH_BIT  id that the next accepted issue receives.
- cdb_valid  in  1  a result is broadcast.
- cdb_rob_id  in  ROB_WIDTH_BIT  entry being completed.
- cdb_value  in  32  result value.
- cdb_next_pc  in  32  resolved next PC (BRANCH only).
- q1_id, q2_id  in  ROB_WIDTH_BIT  forwarding queries.
- q1_ready, q2_ready  out  1  queried entry is complete.
- q1_value, q2_value  out  32  queried value; 0 when not ready.
- write_en  out  1  regfile commit strobe.
- reg_id  out  REG_ID_BIT  committed rd.
- rob_id  out  ROB_WIDTH_BIT  committed entry id.
- value  out  32  committed value.
- store_commit  out  1  pulse: head STORE retired; its id is on rob_id.
- clear_all  out  1  flush pulse to regfile, RS, LSB and decoder.
- redirect_en  out  1  pulse with clear_all.
- redirect_pc  out  32  correct fetch PC.
- halt  out  1  sticky once an EXIT entry retires.

Behaviour:
- Reset: head=tail=count=0, all entries invalid. Every output is 0, including rob_full, tail_id, q*_ready and q*_value.
- Entry fields: valid, ready, type, rd, value, pred_pc, next_pc.
- rob_full = (count == 2^ROB_WIDTH_BIT). It is evaluated from registered count, before this cycle's commit.
- Issue accepted iff issue_valid && !rob_full && !clear_all. Decoder must not issue when rob_full is high; such an issue is dropped.
- Accepted issue writes entry[tail]: ready=issue_ready, value=issue_value. Then tail increments modulo 2^ROB_WIDTH_BIT.
- CDB: entry[cdb_rob_id] sets ready=1 and stores value and next_pc. Ignored if the entry is invalid or clear_all is high.
- Same-cycle CDB to the slot being issued: the issue wins, because that slot was invalid.
- Forwarding is combinational and includes same-cycle CDB bypass. If cdb_valid && cdb_rob_id==qN_id, then qN_ready=1 and qN_value=cdb_value. Otherwise the stored ready/value are returned.
- Commit: each cycle, if entry[head] is valid and ready (stored ready only, no CDB bypass), retire it. The head is freed, head increments, and count updates.
- Count update: count += accepted_issue - commit. Simultaneous issue and commit leave count unchanged. A full ROB can commit and accept in the same cycle only if rob_full was low, so it is effectively one issue per commit.
- Commit outputs are registered, appear the cycle after the retire decision, and are high for exactly one cycle:
  - REG or BRANCH with rd!=0: write_en=1, reg_id=rd, rob_id=head, value=entry value.
  - rd==0: write_en=0.
  - STORE: store_commit=1, rob_id=head.
  - EXIT: halt<=1; after that no further commits or issues are accepted.
  - BRANCH with next_pc != pred_pc (mispredict): clear_all=1, redirect_en=1, redirect_pc=next_pc.
- On a mispredict retire, at the same edge all entries are invalidated and head=tail=count=0. The branch's own rd write (JAL/JALR link) is still emitted in the same cycle as clear_all.
- While clear_all is high, issue and CDB inputs are ignored. tail_id reads 0.
- Reset mid-operation overrides everything: all state cleared and outputs 0 at the next edge.
- rdy_in low: nothing changes. Pulses stay high until rdy_in returns, then drop after one active cycle.

Optional Feature:
- Macro ROB_COMMIT_COUNTER_EN.
- Defined: adds output commit_count [31:0]. It resets to 0 and increments by 1 per retired entry of any type. A mispredicted branch counts once; flushed entries never count.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Test Plan:
- Issue REG rd=5, then CDB id0 value 0x1234 -> next cycle write_en=1, reg_id=5, rob_id=0, value=0x1234.
- Issue 8 REG entries with none ready -> rob_full=1 and tail_id=0; a 9th issue is dropped. CDB id0 -> commit, rob_full drops, and the next issue gets id0 (wrap-around).
- Issue A (id0) and B (id1); CDB id1 first, then id0 -> commits occur in order id0 then id1, on consecutive cycles.
- BRANCH with pred_pc=0x100, CDB next_pc=0x200, with younger entries present -> clear_all=1, redirect_pc=0x200, then count=0 and tail_id=0. A CDB aimed at a flushed id is ignored.
- q1_id=3 while cdb_valid targets id3 with 0xDEAD -> q1_ready=1 and q1_value=0xDEAD in the same cycle.
- STORE then EXIT, both ready -> store_commit pulse with rob_id=0, then halt=1 stays high. Later issues are ignored. With ROB_COMMIT_COUNTER_EN, commit_count=2.
